// File: rtl/memory_access_controller.sv
// memory_access_controller
//
// Memory-side sequencer between the control unit / data register pair and a
// synchronous RAM. A single-cycle read or write request is accepted while the
// controller is idle, the RAM is driven with a registered address (and write
// data/enable for writes), and completion is reported with a one-cycle `done`
// pulse. Reads additionally capture the RAM word into `dr_data` and pulse
// `dr_load` so the data register can latch it.
//
// Ports:
//   clk        system clock, everything on the rising edge
//   rst        synchronous active-high reset
//   rd_req     read request, honoured only while busy=0
//   wr_req     write request, honoured only while busy=0
//   addr_in    request address (from AR)
//   wr_data    write data (from DR data_out)
//   ram_rdata  RAM read data
//   ram_addr   registered RAM address
//   ram_wdata  registered RAM write data
//   ram_we     RAM write enable, one cycle per write
//   dr_data    last captured read word (to DR ram_in)
//   dr_load    one-cycle strobe to DR read
//   busy       transaction in progress
//   done       one-cycle completion pulse (read or write)
//   overrun    sticky: request while busy, or read+write collision
module memory_access_controller #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] dr_data,
    output logic                  dr_load,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_PULSE
    } state_t;

    // The counter is 4 bits wide, which bounds RAM_LATENCY to 1..15.
    localparam logic [3:0] LAT = 4'(RAM_LATENCY);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;

    logic accept_rd;
    logic accept_wr;
    logic rd_finish;
    logic wr_finish;
    logic cnt_inc;
    logic overrun_set;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-edge decisions. A read wins a read/write collision;
    // the dropped write and any request arriving while busy only set overrun.
    always_comb begin
        state_next  = state;
        accept_rd   = 1'b0;
        accept_wr   = 1'b0;
        rd_finish   = 1'b0;
        wr_finish   = 1'b0;
        cnt_inc     = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    accept_rd   = 1'b1;
                    state_next  = RD_WAIT;
                    overrun_set = wr_req;
                end else if (wr_req) begin
                    accept_wr  = 1'b1;
                    state_next = WR_PULSE;
                end
            end
            RD_WAIT: begin
                overrun_set = rd_req | wr_req;
                if (cnt == LAT) begin
                    rd_finish  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WR_PULSE: begin
                overrun_set = rd_req | wr_req;
                wr_finish   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered datapath and outputs. The counter starts at 1 on the
    // accepting edge so that the capture edge lands exactly RAM_LATENCY
    // edges after the request edge. Address and write data are sampled only
    // on acceptance and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            dr_data   <= '0;
            dr_load   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            ram_we  <= accept_wr;
            dr_load <= rd_finish;
            done    <= rd_finish | wr_finish;
            busy    <= (state_next != IDLE);
            overrun <= overrun | overrun_set;
            if (accept_rd || accept_wr) begin
                ram_addr <= addr_in;
            end
            if (accept_wr) begin
                ram_wdata <= wr_data;
            end
            if (rd_finish) begin
                dr_data <= ram_rdata;
            end
            if (accept_rd) begin
                cnt <= 4'd1;
            end else if (rd_finish) begin
                cnt <= 4'd0;
            end else if (cnt_inc) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
// tb_memory_access_controller
//
// Three controller instances share one behavioural RAM image: dut2 uses
// RAM_LATENCY=2 and runs the per-cycle vector table, dut1 and dut4 use
// latencies 1 and 4 for the latency sweep. Each RAM model delays the
// addressed word by RAM_LATENCY-1 registers, so the word is stable at the
// edge RAM_LATENCY edges after the address was latched; earlier edges still
// see the stale word from address 0.
module tb_memory_access_controller;

    logic        clk;
    logic        rst;
    logic        preload;
    logic [7:0]  addr_in;
    logic [15:0] wr_data;
    logic        rd_req2;
    logic        wr_req2;
    logic        rd_req1;
    logic        rd_req4;
    logic        no_wr;

    logic [7:0]  ram_addr2, ram_addr1, ram_addr4;
    logic [15:0] ram_wdata2, ram_wdata1, ram_wdata4;
    logic        ram_we2, ram_we1, ram_we4;
    logic [15:0] dr_data2, dr_data1, dr_data4;
    logic        dr_load2, dr_load1, dr_load4;
    logic        busy2, busy1, busy4;
    logic        done2, done1, done4;
    logic        overrun2, overrun1, overrun4;
    logic [15:0] ram_rdata2, ram_rdata1, ram_rdata4;

    logic [15:0] mem [0:255];
    logic [15:0] pipe4 [0:2];

    int tests_run;
    int tests_failed;

    memory_access_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .rd_req(rd_req2), .wr_req(wr_req2),
        .addr_in(addr_in), .wr_data(wr_data), .ram_rdata(ram_rdata2),
        .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_we(ram_we2),
        .dr_data(dr_data2), .dr_load(dr_load2), .busy(busy2), .done(done2),
        .overrun(overrun2)
    );

    memory_access_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req1), .wr_req(no_wr),
        .addr_in(addr_in), .wr_data(wr_data), .ram_rdata(ram_rdata1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1),
        .dr_data(dr_data1), .dr_load(dr_load1), .busy(busy1), .done(done1),
        .overrun(overrun1)
    );

    memory_access_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .rd_req(rd_req4), .wr_req(no_wr),
        .addr_in(addr_in), .wr_data(wr_data), .ram_rdata(ram_rdata4),
        .ram_addr(ram_addr4), .ram_wdata(ram_wdata4), .ram_we(ram_we4),
        .dr_data(dr_data4), .dr_load(dr_load4), .busy(busy4), .done(done4),
        .overrun(overrun4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM image: preloaded once, then written only by dut2.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 16'd0;
            end
            mem[8'h00] <= 16'hDEAD;
            mem[8'h1A] <= 16'd546;
            mem[8'h20] <= 16'h0BEE;
            mem[8'h3F] <= 16'd463;
        end else if (ram_we2) begin
            mem[ram_addr2] <= ram_wdata2;
        end
    end

    // Read pipelines for the three latencies.
    always @(posedge clk) begin
        ram_rdata2 <= mem[ram_addr2];
        pipe4[0]   <= mem[ram_addr4];
        pipe4[1]   <= pipe4[0];
        pipe4[2]   <= pipe4[1];
    end
    assign ram_rdata1 = mem[ram_addr1];
    assign ram_rdata4 = pipe4[2];

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  e_addr;
        logic [15:0] e_wdata;
        logic        e_we;
        logic [15:0] e_dr;
        logic        e_load;
        logic        e_busy;
        logic        e_done;
        logic        e_ovr;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic r, input logic rd, input logic wr,
        input logic [7:0] a, input logic [15:0] wd,
        input logic [7:0] ea, input logic [15:0] ewd, input logic ewe,
        input logic [15:0] edr, input logic eld, input logic eb,
        input logic ed, input logic eo);
        vec_t v;
        v.rst = r;   v.rd = rd;   v.wr = wr;   v.addr = a;   v.wdata = wd;
        v.e_addr = ea; v.e_wdata = ewd; v.e_we = ewe; v.e_dr = edr;
        v.e_load = eld; v.e_busy = eb; v.e_done = ed; v.e_ovr = eo;
        return v;
    endfunction

    // Drive one table row onto dut2 and let one rising edge pass.
    task automatic applyStimulus(input vec_t v);
        rst     = v.rst;
        rd_req2 = v.rd;
        wr_req2 = v.wr;
        addr_in = v.addr;
        wr_data = v.wdata;
        @(posedge clk);
        #1;
    endtask

    // Compare all dut2 outputs against the row's expectation.
    task automatic checkOutput(input int idx, input vec_t v);
        logic [59:0] got;
        logic [59:0] exp;
        got = {ram_addr2, ram_wdata2, ram_we2, dr_data2, dr_load2, busy2, done2, overrun2, 11'd0};
        exp = {v.e_addr, v.e_wdata, v.e_we, v.e_dr, v.e_load, v.e_busy, v.e_done, v.e_ovr, 11'd0};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL vec%0d: got addr=%h wdata=%0d we=%b dr=%0d load=%b busy=%b done=%b ovr=%b, expected addr=%h wdata=%0d we=%b dr=%0d load=%b busy=%b done=%b ovr=%b",
                     idx, ram_addr2, ram_wdata2, ram_we2, dr_data2, dr_load2, busy2, done2, overrun2,
                     v.e_addr, v.e_wdata, v.e_we, v.e_dr, v.e_load, v.e_busy, v.e_done, v.e_ovr);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Read 0x3F on the dut with the given latency and count edges to done.
    task automatic runLatency(input int lat);
        int   edges;
        logic d;
        logic [15:0] dd;
        logic ld;
        addr_in = 8'h3F;
        rd_req1 = (lat == 1);
        rd_req4 = (lat == 4);
        @(posedge clk);
        #1;
        rd_req1 = 1'b0;
        rd_req4 = 1'b0;
        edges = 0;
        d = 1'b0;
        while (!d && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            d = (lat == 1) ? done1 : done4;
        end
        dd = (lat == 1) ? dr_data1 : dr_data4;
        ld = (lat == 1) ? dr_load1 : dr_load4;
        checkValue($sformatf("lat%0d_edges", lat), edges, lat);
        checkValue($sformatf("lat%0d_dr_data", lat), int'(dd), 463);
        checkValue($sformatf("lat%0d_dr_load", lat), int'(ld), 1);
        @(posedge clk);
        #1;
        d  = (lat == 1) ? done1 : done4;
        checkValue($sformatf("lat%0d_done_pulse", lat), int'(d), 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        preload  = 1'b1;
        addr_in  = 8'h00;
        wr_data  = 16'd0;
        rd_req2  = 1'b0;
        wr_req2  = 1'b0;
        rd_req1  = 1'b0;
        rd_req4  = 1'b0;
        no_wr    = 1'b0;

        //            rst rd wr addr   wdata     e_addr e_wdata  we e_dr      ld bsy dn ovr
        vecs[0]  = mk(1, 0, 0, 8'h00, 16'd0,    8'h00, 16'd0,   0, 16'd0,    0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 8'h00, 16'd0,    8'h00, 16'd0,   0, 16'd0,    0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 8'h1A, 16'd0,    8'h1A, 16'd0,   0, 16'd0,    0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 8'h77, 16'd1234, 8'h1A, 16'd0,   0, 16'd0,    0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 8'h77, 16'd1234, 8'h1A, 16'd0,   0, 16'd546,  1, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 8'h00, 16'd0,    8'h1A, 16'd0,   0, 16'd546,  0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 8'h05, 16'd264,  8'h05, 16'd264, 1, 16'd546,  0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 8'h44, 16'd999,  8'h05, 16'd264, 0, 16'd546,  0, 0, 1, 0);
        vecs[8]  = mk(0, 0, 0, 8'h00, 16'd0,    8'h05, 16'd264, 0, 16'd546,  0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 8'h05, 16'd0,    8'h05, 16'd264, 0, 16'd546,  0, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 8'h00, 16'd0,    8'h05, 16'd264, 0, 16'd546,  0, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 8'h00, 16'd0,    8'h05, 16'd264, 0, 16'd264,  1, 0, 1, 0);
        vecs[12] = mk(0, 0, 1, 8'h10, 16'd155,  8'h10, 16'd155, 1, 16'd264,  0, 1, 0, 0);
        vecs[13] = mk(0, 0, 0, 8'h00, 16'd0,    8'h10, 16'd155, 0, 16'd264,  0, 0, 1, 0);
        vecs[14] = mk(0, 1, 0, 8'h10, 16'd0,    8'h10, 16'd155, 0, 16'd264,  0, 1, 0, 0);
        vecs[15] = mk(0, 0, 0, 8'h00, 16'd0,    8'h10, 16'd155, 0, 16'd264,  0, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 8'h00, 16'd0,    8'h10, 16'd155, 0, 16'd155,  1, 0, 1, 0);
        vecs[17] = mk(0, 1, 1, 8'h20, 16'd777,  8'h20, 16'd155, 0, 16'd155,  0, 1, 0, 1);
        vecs[18] = mk(0, 0, 1, 8'h33, 16'd888,  8'h20, 16'd155, 0, 16'd155,  0, 1, 0, 1);
        vecs[19] = mk(0, 0, 0, 8'h00, 16'd0,    8'h20, 16'd155, 0, 16'h0BEE, 1, 0, 1, 1);
        vecs[20] = mk(0, 0, 0, 8'h00, 16'd0,    8'h20, 16'd155, 0, 16'h0BEE, 0, 0, 0, 1);
        vecs[21] = mk(0, 1, 0, 8'h1A, 16'd0,    8'h1A, 16'd155, 0, 16'h0BEE, 0, 1, 0, 1);
        vecs[22] = mk(0, 0, 0, 8'h00, 16'd0,    8'h1A, 16'd155, 0, 16'h0BEE, 0, 1, 0, 1);
        vecs[23] = mk(1, 0, 0, 8'h00, 16'd0,    8'h00, 16'd0,   0, 16'd0,    0, 0, 0, 0);
        vecs[24] = mk(0, 0, 0, 8'h00, 16'd0,    8'h00, 16'd0,   0, 16'd0,    0, 0, 0, 0);
        vecs[25] = mk(0, 0, 0, 8'h00, 16'd0,    8'h00, 16'd0,   0, 16'd0,    0, 0, 0, 0);

        // One reset edge with the RAM image preload.
        @(posedge clk);
        #1;
        preload = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        rst = 1'b0;
        runLatency(1);
        runLatency(4);

        // Neither sweep instance should ever have written.
        checkValue("sweep_no_write", int'(ram_we1 | ram_we4), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
